// File: rtl/clock_supervisor.sv
// PLL lock supervisor: synchronises LOCK, times the PLL reset pulse and releases downstream resets in staggered order.
// Timeout retry and terminal FAULT are present only when CLOCK_SUPERVISOR_RETRY_EN is defined.
module clock_supervisor #(
    parameter int  CH             = 2,
    parameter int  RST_CYCLES     = 16,
    parameter int  SETTLE_CYCLES  = 1024,
    parameter int  STAGGER        = 8,
    parameter int  TIMEOUT_CYCLES = 65536,
    parameter int  MAX_RETRY      = 3,
    localparam int RW             = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pll_lock,
    output logic          pll_rst,
    output logic [CH-1:0] rst_out,
    output logic          locked,
    output logic          fault,
    output logic [RW-1:0] retry_cnt
);

    localparam int MAX_A   = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
    localparam int MAX_B   = (TIMEOUT_CYCLES > CH * STAGGER) ? TIMEOUT_CYCLES : CH * STAGGER;
    localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] REL_LAST    = CNT_W'((CH - 1) * STAGGER);
`ifdef CLOCK_SUPERVISOR_RETRY_EN
    localparam logic [RW-1:0]    MAX_R       = RW'(MAX_RETRY);
`endif

    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_SETTLE    = 3'd2,
        S_RELEASE   = 3'd3,
        S_RUN       = 3'd4,
        S_FAULT     = 3'd5
    } state_t;

    logic [1:0]       sync_q, sync_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cnt_inc;
    logic             pll_rst_q, pll_rst_d;
    logic [CH-1:0]    rst_out_q, rst_out_d;
    logic             locked_q, locked_d;
    logic             fault_q, fault_d;
    logic [RW-1:0]    retry_q, retry_d;
    logic             lock_s;

    // Channels whose release slot coincides with counter value c.
    function automatic logic [CH-1:0] release_mask(input logic [CNT_W-1:0] c);
        logic [CH-1:0] m;
        m = {CH{1'b0}};
        for (int i = 0; i < CH; i++) begin
            m[i] = (c == CNT_W'(i * STAGGER));
        end
        return m;
    endfunction

    assign lock_s = sync_q[1];

    // Synchroniser shift for the asynchronous LOCK input.
    always_comb begin
        sync_d = {sync_q[0], pll_lock};
    end

    // Next-state, shared counter and retry bookkeeping.
    always_comb begin
        state_d = state_q;
        cnt_inc = 1'b1;
        retry_d = retry_q;
        case (state_q)
            S_PLL_RST: begin
                if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
                else                   state_d = S_PLL_RST;
            end
            S_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = S_SETTLE;
                end else if (cnt_q == TO_LAST) begin
`ifdef CLOCK_SUPERVISOR_RETRY_EN
                    if (retry_q < MAX_R) begin
                        retry_d = retry_q + RW'(1);
                        state_d = S_PLL_RST;
                    end else begin
                        state_d = S_FAULT;
                    end
`else
                    // Without retry the wait is unbounded; park the counter at its last value.
                    cnt_inc = 1'b0;
`endif
                end else begin
                    state_d = S_WAIT_LOCK;
                end
            end
            S_SETTLE: begin
                if (!lock_s)                   state_d = S_WAIT_LOCK;
                else if (cnt_q == SETTLE_LAST) state_d = S_RELEASE;
                else                           state_d = S_SETTLE;
            end
            S_RELEASE: begin
                if (!lock_s)                state_d = S_PLL_RST;
                else if (cnt_q == REL_LAST) state_d = S_RUN;
                else                        state_d = S_RELEASE;
            end
            S_RUN: begin
                cnt_inc = 1'b0;
                if (!lock_s) state_d = S_PLL_RST;
                else         state_d = S_RUN;
            end
            S_FAULT: begin
                cnt_inc = 1'b0;
                state_d = S_FAULT;
            end
            default: begin
                cnt_inc = 1'b0;
                state_d = S_PLL_RST;
            end
        endcase

        if (state_d != state_q) cnt_d = {CNT_W{1'b0}};
        else if (cnt_inc)       cnt_d = cnt_q + CNT_W'(1);
        else                    cnt_d = cnt_q;

`ifdef CLOCK_SUPERVISOR_RETRY_EN
        // A completed release ends the lock campaign.
        if ((state_d == S_RELEASE) && (cnt_d == REL_LAST)) retry_d = {RW{1'b0}};
        else                                               retry_d = retry_d;
`else
        retry_d = {RW{1'b0}};
`endif
    end

    // Output values for the upcoming state, so every output is a flop aligned with the state.
    always_comb begin
        pll_rst_d = (state_d == S_PLL_RST) || (state_d == S_FAULT);
        rst_out_d = {CH{1'b1}};
        locked_d  = 1'b0;
        case (state_d)
            S_RELEASE: begin
                rst_out_d = rst_out_q & ~release_mask(cnt_d);
                locked_d  = (cnt_d == REL_LAST);
            end
            S_RUN: begin
                rst_out_d = {CH{1'b0}};
                locked_d  = 1'b1;
            end
            default: begin
                rst_out_d = {CH{1'b1}};
                locked_d  = 1'b0;
            end
        endcase
`ifdef CLOCK_SUPERVISOR_RETRY_EN
        fault_d = (state_d == S_FAULT);
`else
        fault_d = 1'b0;
`endif
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= 2'b00;
            state_q   <= S_PLL_RST;
            cnt_q     <= {CNT_W{1'b0}};
            pll_rst_q <= 1'b1;
            rst_out_q <= {CH{1'b1}};
            locked_q  <= 1'b0;
            fault_q   <= 1'b0;
            retry_q   <= {RW{1'b0}};
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pll_rst_q <= pll_rst_d;
            rst_out_q <= rst_out_d;
            locked_q  <= locked_d;
            fault_q   <= fault_d;
            retry_q   <= retry_d;
        end
    end

    assign pll_rst   = pll_rst_q;
    assign rst_out   = rst_out_q;
    assign locked    = locked_q;
    assign fault     = fault_q;
    assign retry_cnt = retry_q;

endmodule
